// File: rtl/fp32_mul_issue.sv
// Issue/capture stage around a combinational FP32 multiplier: operand FIFO in front,
// registered valid/ready result port behind, plus saturating NaN/Inf result counters.
module fp32_mul_issue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    output logic [31:0]              mul_a,
    output logic [31:0]              mul_b,
    input  logic [31:0]              mul_res,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_data,
    output logic [CNT_W-1:0]         nan_cnt,
    output logic [CNT_W-1:0]         inf_cnt,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;
    logic [CNT_W-1:0] inf_cnt_q, inf_cnt_d;

    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        res_is_nan;
    logic        res_is_inf;
    logic [63:0] head;

    assign fifo_empty = (level_q == '0);
    assign in_ready   = (level_q != LVL_FULL);
    assign push       = in_valid && in_ready && !flush;
    // Pop only when the result register is free or being drained this cycle.
    assign pop        = !fifo_empty && (!res_valid_q || res_ready) && !flush;

    assign head  = mem_q[rd_ptr_q];
    assign mul_a = fifo_empty ? 32'h0 : head[63:32];
    assign mul_b = fifo_empty ? 32'h0 : head[31:0];

    assign res_is_nan = (mul_res[30:23] == 8'hFF) && (mul_res[22:0] != 23'h0);
    assign res_is_inf = (mul_res[30:23] == 8'hFF) && (mul_res[22:0] == 23'h0);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        nan_cnt_d   = nan_cnt_q;
        inf_cnt_d   = inf_cnt_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            res_valid_d = 1'b0;
            nan_cnt_d   = '0;
            inf_cnt_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                res_valid_d = 1'b1;
                res_data_d  = mul_res;
                if (res_is_nan && (nan_cnt_q != '1)) begin
                    nan_cnt_d = nan_cnt_q + CNT_ONE;
                end
                if (res_is_inf && (inf_cnt_q != '1)) begin
                    inf_cnt_d = inf_cnt_q + CNT_ONE;
                end
            end else if (res_ready && res_valid_q) begin
                res_valid_d = 1'b0;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            nan_cnt_q   <= '0;
            inf_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            nan_cnt_q   <= nan_cnt_d;
            inf_cnt_q   <= inf_cnt_d;
        end
    end

    // Storage carries no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign nan_cnt   = nan_cnt_q;
    assign inf_cnt   = inf_cnt_q;
    assign level     = level_q;
endmodule

// File: tb/tb_fp32_mul_issue.sv
// Randomised and directed bench for fp32_mul_issue against a queue-based transaction model;
// a second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_fp32_mul_issue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;

    logic        in_ready, res_valid, in_ready2, res_valid2;
    logic [31:0] mul_a, mul_b, mul_res, res_data;
    logic [31:0] mul_a2, mul_b2, mul_res2, res_data2;
    logic [15:0] nan_cnt, inf_cnt;
    logic [1:0]  nan_cnt2, inf_cnt2;
    logic [2:0]  level, level2;

    int errors = 0;
    int checks = 0;

    logic [63:0] mq[$];
    bit          m_rv;
    logic [31:0] m_rd;
    int          m_nan, m_inf, m_nan2, m_inf2;

    always #5 clk = ~clk;

    // Behavioural FP32 multiplier (denormals flushed, truncating) standing in for the real one.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        int          e;
        logic [22:0] m;
        bit a_nan, b_nan, a_inf, b_inf, a_z, b_z;
        s     = a[31] ^ b[31];
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_z   = (a[30:23] == 8'h00);
        b_z   = (b[30:23] == 8'h00);
        if (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) return 32'h7FC00000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
        if (a_z || b_z) return {s, 31'h0};
        p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], m};
    endfunction

    always_comb mul_res  = fmul(mul_a, mul_b);
    always_comb mul_res2 = fmul(mul_a2, mul_b2);

    fp32_mul_issue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .nan_cnt(nan_cnt), .inf_cnt(inf_cnt), .level(level)
    );

    fp32_mul_issue #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a2), .mul_b(mul_b2), .mul_res(mul_res2),
        .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2),
        .nan_cnt(nan_cnt2), .inf_cnt(inf_cnt2), .level(level2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_rv   = 0;
        m_nan  = 0;
        m_inf  = 0;
        m_nan2 = 0;
        m_inf2 = 0;
    endtask

    task automatic check_outputs();
        check("level", level, mq.size());
        check("in_ready", in_ready, (mq.size() < DEPTH));
        check("res_valid", res_valid, m_rv);
        if (m_rv) check("res_data", res_data, m_rd);
        check("mul_a", mul_a, (mq.size() != 0) ? mq[0][63:32] : 32'h0);
        check("mul_b", mul_b, (mq.size() != 0) ? mq[0][31:0] : 32'h0);
        check("nan_cnt", nan_cnt, m_nan);
        check("inf_cnt", inf_cnt, m_inf);
        check("nan_sat", nan_cnt2, m_nan2);
        check("inf_sat", inf_cnt2, m_inf2);
    endtask

    // One clock: drive inputs, predict the transaction outcome, advance, then compare.
    task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input bit rr, input bit fl);
        bit          do_push, do_pop;
        logic [63:0] p;
        logic [31:0] r;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        res_ready = rr;
        flush     = fl;
        do_push   = v && (mq.size() < DEPTH);
        do_pop    = (mq.size() != 0) && (!m_rv || rr);
        @(posedge clk);
        #1;
        if (fl) begin
            model_clear();
        end else begin
            if (do_pop) begin
                p    = mq.pop_front();
                r    = fmul(p[63:32], p[31:0]);
                m_rd = r;
                m_rv = 1;
                if (r[30:23] == 8'hFF && r[22:0] != 0) begin
                    if (m_nan < 65535) m_nan++;
                    if (m_nan2 < 3) m_nan2++;
                end
                if (r[30:23] == 8'hFF && r[22:0] == 0) begin
                    if (m_inf < 65535) m_inf++;
                    if (m_inf2 < 3) m_inf2++;
                end
            end else if (rr && m_rv) begin
                m_rv = 0;
            end
            if (do_push) mq.push_back({a, b});
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        $display("cyc t=%0t v=%0b a=%h b=%h rr=%0b fl=%0b lvl=%0d rv=%0b rd=%h",
                 $time, v, a, b, rr, fl, level, res_valid, res_data);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 15))
            0:       return {x[31], 8'hFF, 23'h0};
            1:       return {x[31], 31'h0};
            2:       return {x[31], 8'hFF, x[22:1], 1'b1};
            default: return {x[31], 8'($urandom_range(100, 154)), x[22:0]};
        endcase
    endfunction

    initial begin
        int          vcnt;
        int          maxl;
        logic [31:0] r0, r1;

        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", level, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic product and two-edge latency.
        cycle(1, 32'h3F800000, 32'h40000000, 1, 0);
        check("lat_not_yet", res_valid, 0);
        cycle(0, 0, 0, 1, 0);
        check("lat_valid", res_valid, 1);
        check("lat_data", res_data, 32'h40000000);
        cycle(0, 0, 0, 1, 0);

        // Special values.
        cycle(1, 32'h7F800000, 32'h00000000, 1, 0);
        cycle(1, 32'h7F800000, 32'h3F800000, 1, 0);
        r0 = res_data;
        cycle(0, 0, 0, 1, 0);
        r1 = res_data;
        check("inf_x_zero", r0, 32'h7FC00000);
        check("inf_x_one", r1, 32'h7F800000);
        check("nan_cnt_one", nan_cnt, 1);
        check("inf_cnt_one", inf_cnt, 1);
        cycle(0, 0, 0, 1, 0);

        // Back-pressure: fill result register plus FIFO, then drain in order.
        for (int i = 0; i < 5; i++) cycle(1, rand_op(), rand_op(), 0, 0);
        check("full_level", level, 4);
        check("full_in_ready", in_ready, 0);
        cycle(1, 32'h3F800000, 32'h3F800000, 0, 0);
        check("full_blocked", level, 4);
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, 0);
        check("drained", level, 0);

        // Sustained throughput with pointer wrap.
        vcnt = 0;
        maxl = 0;
        for (int i = 0; i < 3 * DEPTH + 1; i++) begin
            cycle(i < 3 * DEPTH, rand_op(), rand_op(), 1, 0);
            if (res_valid) vcnt++;
            if (int'(level) > maxl) maxl = int'(level);
        end
        check("tput_valid_cycles", vcnt, 3 * DEPTH);
        check("tput_max_level", maxl, 1);
        cycle(0, 0, 0, 1, 0);

        // Flush coincident with push and accept.
        for (int i = 0; i < 3; i++) cycle(1, rand_op(), rand_op(), 0, 0);
        cycle(1, 32'h3F800000, 32'h40400000, 1, 1);
        check("flush_level", level, 0);
        check("flush_res_valid", res_valid, 0);
        check("flush_in_ready", in_ready, 1);

        // Saturation of the 2-bit counters.
        for (int i = 0; i < 5; i++) cycle(1, 32'h7FC00000, 32'h3F800000, 1, 0);
        cycle(0, 0, 0, 1, 0);
        check("nan_sat3", nan_cnt2, 3);
        check("nan_full5", nan_cnt, 5);
        cycle(1, 0, 0, 1, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, rand_op(), rand_op(), $urandom_range(0, 2) != 0, i % 97 == 96);

        // Async reset mid-cycle with data in flight.
        cycle(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(1, rand_op(), rand_op(), 0, 0);
        check("pre_rst_level", level, 3);
        check("pre_rst_valid", res_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_level", level, 0);
        check("arst_res_valid", res_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_nan", nan_cnt, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1, 32'h40000000, 32'h40400000, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("post_rst_data", res_data, 32'h40C00000);
        cycle(0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
